// File: rtl/mvm3_host_driver.sv
// Host-side sequencer for the 3x3 MVM block: streams a host-loaded 15-byte
// operand frame out, captures the three results back, and times the exchange.
module mvm3_host_driver #(
    parameter int FRAME_LEN = 15,
    parameter int N_RES     = 3,
    parameter int LAT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             start,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [7:0]       data_out,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [15:0]      data_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      res0,
    output logic [15:0]      res1,
    output logic [15:0]      res2,
    output logic [LAT_W-1:0] latency
);
    // state | meaning
    // IDLE  | after reset; host may write the frame buffer, start launches
    // SEND  | frame bytes offered to the MVM slave port in address order
    // RECV  | results accepted from the MVM master port into res[0..2]
    // DONE  | results and latency held; host may rewrite and relaunch
    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    localparam logic [3:0] FRAME_LIM = 4'(FRAME_LEN);
    localparam logic [3:0] LAST_BYTE = 4'(FRAME_LEN - 1);
    localparam logic [1:0] LAST_RES  = 2'(N_RES - 1);

    state_t           state_q, state_d;
    logic [3:0]       send_ptr_q, send_ptr_d;
    logic [1:0]       rx_ptr_q, rx_ptr_d;
    logic [LAT_W-1:0] latency_q, latency_d;
    logic [LAT_W-1:0] lat_inc;
    logic [7:0]       frame_q [FRAME_LEN];
    logic [7:0]       frame_d [FRAME_LEN];
    logic [15:0]      res_q [N_RES];
    logic [15:0]      res_d [N_RES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            send_ptr_q <= '0;
            rx_ptr_q   <= '0;
            latency_q  <= '0;
            for (int i = 0; i < FRAME_LEN; i++) frame_q[i] <= '0;
            for (int i = 0; i < N_RES; i++) res_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            send_ptr_q <= send_ptr_d;
            rx_ptr_q   <= rx_ptr_d;
            latency_q  <= latency_d;
            frame_q    <= frame_d;
            res_q      <= res_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        send_ptr_d = send_ptr_q;
        rx_ptr_d   = rx_ptr_q;
        latency_d  = latency_q;
        frame_d    = frame_q;
        res_d      = res_q;

        s_valid  = (state_q == SEND);
        m_ready  = (state_q == RECV);
        busy     = s_valid || m_ready;
        done     = (state_q == DONE);
        data_out = s_valid ? frame_q[send_ptr_q] : '0;
        // Latency sticks at all-ones instead of wrapping.
        lat_inc  = (latency_q == '1) ? latency_q : latency_q + 1'b1;

        case (state_q)
            IDLE, DONE: begin
                if (wr_en && (wr_addr < FRAME_LIM)) frame_d[wr_addr] = wr_data;
                if (start) begin
                    state_d    = SEND;
                    send_ptr_d = '0;
                    rx_ptr_d   = '0;
                    latency_d  = '0;
                    for (int i = 0; i < N_RES; i++) res_d[i] = '0;
                end
            end
            SEND: begin
                // Counting begins with the first accepted byte; a nonzero count means it has begun.
                if (s_ready) begin
                    send_ptr_d = send_ptr_q + 1'b1;
                    latency_d  = lat_inc;
                    if (send_ptr_q == LAST_BYTE) begin
                        state_d    = RECV;
                        send_ptr_d = '0;
                    end
                end else if (latency_q != '0) begin
                    latency_d = lat_inc;
                end
            end
            RECV: begin
                latency_d = lat_inc;
                if (m_valid) begin
                    res_d[rx_ptr_q] = data_in;
                    rx_ptr_d        = rx_ptr_q + 1'b1;
                    if (rx_ptr_q == LAST_RES) state_d = DONE;
                end
            end
        endcase
    end

    assign res0    = res_q[0];
    assign res1    = res_q[1];
    assign res2    = res_q[2];
    assign latency = latency_q;
endmodule

// File: tb/tb_mvm3_host_driver.sv
// Bench for mvm3_host_driver: directed frames against a counter/timestamp model
// of the frame exchange, with literal result and latency expectations.
module tb_mvm3_host_driver;
    logic        clk = 0, reset = 1, wr_en = 0, start = 0, s_ready = 0, m_valid = 0;
    logic [3:0]  wr_addr = 0;
    logic [7:0]  wr_data = 0;
    logic [15:0] data_in = 0;
    logic        s_valid, m_ready, busy, done;
    logic [7:0]  data_out;
    logic [15:0] res0, res1, res2, latency;

    mvm3_host_driver dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .s_valid(s_valid), .s_ready(s_ready), .data_out(data_out),
        .m_valid(m_valid), .m_ready(m_ready), .data_in(data_in), .busy(busy),
        .done(done), .res0(res0), .res1(res1), .res2(res2), .latency(latency)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, tot_cnt = 0;
    bit bp = 0, chk_en = 0;
    logic [7:0]  tb_frame [15];
    logic [15:0] yexp [3];
    logic [7:0]  sentq [$];
    int rx_cnt = 0, mon_cyc = 0, t_first = 0, rcount = 0, lat_meas = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: frame progress as byte/result counts, latency from timestamps.
    logic [7:0]  mframe [15];
    logic [15:0] mres [3];
    logic [15:0] mlat;
    int sent, got, mcyc, mfirst;
    bit active, mdone, counting;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) mframe[i] = 0;
            for (int i = 0; i < 3; i++) mres[i] = 0;
            mlat = 0; sent = 0; got = 0; mcyc = 0; mfirst = 0;
            active = 0; mdone = 0; counting = 0;
        end else begin
            mcyc++;
            if (!active) begin
                if (wr_en && wr_addr < 15) mframe[wr_addr] = wr_data;
                if (start) begin
                    active = 1; mdone = 0; sent = 0; got = 0; mlat = 0; counting = 0;
                    for (int i = 0; i < 3; i++) mres[i] = 0;
                end
            end else if (sent < 15) begin
                if (s_ready) begin
                    if (sent == 0) begin counting = 1; mfirst = mcyc; end
                    sent++;
                end
            end else if (m_valid) begin
                mres[got] = data_in;
                got++;
                if (got == 3) begin active = 0; mdone = 1; end
            end
            if (counting) mlat = (mcyc - mfirst + 1 > 65535) ? 16'hFFFF : 16'(mcyc - mfirst + 1);
            if (mdone) counting = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_sv;
            exp_sv = active && sent < 15;
            chk("s_valid", s_valid, exp_sv);
            chk("data_out", data_out, exp_sv ? mframe[sent < 15 ? sent : 0] : 8'h00);
            chk("m_ready", m_ready, active && sent == 15 && got < 3);
            chk("busy", busy, active);
            chk("done", done, mdone);
            chk("res0", res0, mres[0]);
            chk("res1", res1, mres[1]);
            chk("res2", res2, mres[2]);
            chk("latency", latency, mlat);
        end
    end

    // MVM stand-in: handshake pattern plus results derived from the bench's frame.
    always @(posedge clk) begin
        if (reset || start) rx_cnt = 0;
        else if (m_valid && m_ready) rx_cnt++;
        #1;
        if (bp) begin s_ready = ~s_ready; m_valid = ~m_valid; end
        else begin s_ready = 1; m_valid = 1; end
        data_in = yexp[rx_cnt > 2 ? 2 : rx_cnt];
    end

    always @(posedge clk) begin
        mon_cyc++;
        if (s_valid && s_ready) begin
            if (sentq.size() == 0) t_first = mon_cyc;
            sentq.push_back(data_out);
        end
        if (m_valid && m_ready) begin
            rcount++;
            if (rcount == 3) lat_meas = mon_cyc - t_first + 1;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic calc_y();
        for (int r = 0; r < 3; r++) begin
            int acc;
            acc = $signed(tb_frame[9 + r]);
            for (int c = 0; c < 3; c++)
                acc += $signed(tb_frame[3 * r + c]) * $signed(tb_frame[12 + c]);
            yexp[r] = 16'(acc);
        end
    endtask

    task automatic write(input int a, input logic [7:0] d);
        wr_en = 1; wr_addr = 4'(a); wr_data = d;
        tick();
        wr_en = 0;
    endtask

    // Loads bytes 0..13, then writes byte 14 in the same cycle as start.
    task automatic load_and_launch();
        calc_y();
        for (int i = 0; i < 14; i++) write(i, tb_frame[i]);
        sentq.delete(); rcount = 0;
        wr_en = 1; wr_addr = 14; wr_data = tb_frame[14]; start = 1;
        tick();
        wr_en = 0; start = 0;
    endtask

    task automatic launch();
        sentq.delete(); rcount = 0;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin tick(); n++; end
        chk("done_reached", done, 1);
    endtask

    task automatic check_sent();
        chk("sent_len", sentq.size(), 15);
        for (int i = 0; i < 15; i++)
            chk($sformatf("sent[%0d]", i), (i < sentq.size()) ? sentq[i] : 8'hxx, tb_frame[i]);
    endtask

    task automatic check_res(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        chk("lit_res0", res0, a);
        chk("lit_res1", res1, b);
        chk("lit_res2", res2, c);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_valid", s_valid, 0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_res0", res0, 0);
        chk("rst_latency", latency, 0);
        #2 reset = 0;
        tick();
        chk_en = 1;

        // Basic frame, zero stalls; also pins latency.
        tb_frame = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
                     8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
        load_and_launch();
        wait_done(200);
        check_sent();
        check_res(16'd15, 16'd33, 16'd51);
        chk("lit_latency", latency, 18);
        chk("latency_meas", latency, lat_meas);
        repeat (5) tick();
        chk("latency_frozen", latency, 18);

        // Signed extremes, loaded while in DONE.
        tb_frame = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F};
        load_and_launch();
        wait_done(200);
        check_sent();
        check_res(16'hFE03, 16'hFE03, 16'hFE03);

        // Backpressure on both sides.
        bp = 1;
        tb_frame = '{8'h02, 8'hFD, 8'h05, 8'hF9, 8'h00, 8'h04, 8'h01, 8'h01, 8'hFF,
                     8'h0A, 8'hEC, 8'h1E, 8'h03, 8'hFE, 8'h01};
        load_and_launch();
        wait_done(400);
        check_sent();
        check_res(16'd27, 16'hFFDB, 16'd30);

        // Write and start while busy are ignored; a repeat frame matches.
        launch();
        repeat (4) tick();
        wr_en = 1; wr_addr = 0; wr_data = 8'h55; start = 1;
        tick();
        wr_en = 0; start = 0;
        wait_done(400);
        check_sent();
        check_res(16'd27, 16'hFFDB, 16'd30);
        launch();
        wait_done(400);
        check_sent();
        check_res(16'd27, 16'hFFDB, 16'd30);
        bp = 0;

        // Reset after 7 bytes, then a fresh frame.
        launch();
        begin
            int n = 0;
            while (sentq.size() < 7 && n < 50) begin tick(); n++; end
        end
        chk("reached_7_bytes", sentq.size(), 7);
        #2 reset = 1;
        #1;
        chk("mid_rst_s_valid", s_valid, 0);
        chk("mid_rst_m_ready", m_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res0", res0, 0);
        chk("mid_rst_latency", latency, 0);
        @(posedge clk); #3 reset = 0;
        tick();
        tb_frame = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
                     8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
        load_and_launch();
        wait_done(200);
        check_sent();
        check_res(16'd15, 16'd33, 16'd51);
        chk("lit_latency_after_rst", latency, 18);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mvm3_host_driver.md
Name: mvm3_host_driver

Overview:
Initiator for the 3x3 matrix-vector-multiply stream interface. Holds a 15-byte operand frame written by a host port, streams it to the MVM slave port (valid/ready), then accepts the three signed 16-bit results from the MVM master port and exposes them to the host. Used as the on-chip sequencer in front of the MVM block and as the reusable driver in its system bench.

Parameters:
FRAME_LEN, 15, bytes per frame: M row-major (addr 0-8), then b (9-11), then x (12-14)
N_RES, 3, results per frame
LAT_W, 16, width of the latency counter

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  host write strobe into the frame buffer
wr_addr  in  4  frame buffer address, 0..14; 15 is ignored
wr_data  in  8  signed operand byte
start  in  1  one-cycle pulse that launches a frame
s_valid  out  1  to MVM s_valid
s_ready  in  1  from MVM s_ready
data_out  out  8  to MVM data_in
m_valid  in  1  from MVM m_valid
m_ready  out  1  to MVM m_ready
data_in  in  16  signed result from MVM data_out
busy  out  1  high in SEND and RECV
done  out  1  high in DONE
res0, res1, res2  out  16 each  captured results, rows 0..2
latency  out  LAT_W  cycles from the first accepted byte to the last accepted result

Behaviour:
- States: IDLE, SEND, RECV, DONE. Reset to IDLE asynchronously; all outputs 0; frame buffer, results, pointers and latency cleared.
- IDLE: wr_en with wr_addr<15 writes the frame buffer. A start pulse moves to SEND next cycle with send_ptr=0, rx_ptr=0, latency=0.
- DONE: same as IDLE, and done=1. A start pulse clears done, results and latency, and moves to SEND. Writes in DONE are allowed.
- SEND:
  - s_valid=1, data_out=frame[send_ptr].
  - Transfer happens on s_valid && s_ready. send_ptr increments.
  - data_out is held stable while s_ready=0.
  - After the transfer at send_ptr=14, s_valid drops the next cycle and the state moves to RECV.
- RECV:
  - m_ready=1. On m_valid && m_ready, data_in is captured into res[rx_ptr] and rx_ptr increments.
  - After the third capture, the state moves to DONE next cycle and m_ready drops.
  - m_valid outside RECV is ignored; m_ready stays 0 there.
- latency:
  - Starts at 1 on the cycle of the first SEND transfer.
  - Increments every cycle through SEND and RECV, including the final capture cycle.
  - Frozen in DONE. Saturates at all-ones (no wrap).
- While busy, wr_en and start are ignored; the buffer is unchanged.
- start and wr_en in the same IDLE cycle: the write lands first, and the frame sent includes it.
- Reset mid-frame: immediate return to IDLE. s_valid and m_ready deassert asynchronously. Partial results are discarded.
- No arithmetic on data. Values pass through bit-exact as two's complement.

Test Plan:
- Basic frame: load M=1..9, b=1,1,1, x=1,2,3; start with s_ready and m_valid always high → 15 bytes sent in order 1..9,1,1,1,1,2,3; res0=15, res1=33, res2=51; done=1.
- Signed extremes: M all -1 (0xFF), b all -128, x all 127 → bytes sent unchanged; res0=res1=res2=-509 (0xFE03).
- Backpressure: s_ready alternating 1/0 on both SEND bytes and RECV results (m_valid gapped) → data_out stable whenever s_ready=0; no byte duplicated or skipped; results correct.
- Busy lockout: wr_en to addr 0 with 0x55, then start, both issued mid-SEND → frame and sequence unaffected; second frame after DONE matches the first.
- Reset mid-frame: assert reset after 7 bytes → s_valid=0 the same cycle; state IDLE; results 0; a fresh load and start completes correctly.
- Latency: fixed MVM response with zero stalls → latency equals bench-measured cycles from first transfer to third result; value unchanged while in DONE.
